// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Purpose  : Bundles the I-cache, D-cache and unified-memory buses of the
//            arbiter. The master modport is the arbiter's view of the bus.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if;
    // instruction-cache side
    logic         i_read;
    logic [5:0]   i_address;
    logic [127:0] i_readdata;
    logic         i_busywait;
    // data-cache side
    logic         d_read;
    logic         d_write;
    logic [5:0]   d_address;
    logic [31:0]  d_writedata;
    logic [31:0]  d_readdata;
    logic         d_busywait;
    // unified-memory side
    logic         mem_read;
    logic         mem_write;
    logic [8:0]   mem_address;
    logic [31:0]  mem_writedata;
    logic [31:0]  mem_readdata;
    logic         mem_busywait;

    modport master (
        input  i_read, i_address, d_read, d_write, d_address, d_writedata,
               mem_readdata, mem_busywait,
        output i_readdata, i_busywait, d_readdata, d_busywait,
               mem_read, mem_write, mem_address, mem_writedata
    );

    modport slave (
        output i_read, i_address, d_read, d_write, d_address, d_writedata,
               mem_readdata, mem_busywait,
        input  i_readdata, i_busywait, d_readdata, d_busywait,
               mem_read, mem_write, mem_address, mem_writedata
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one unified memory between an instruction cache (4-word
//            block reads) and a data cache (1-word reads/writes).
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter logic [8:0] D_BASE = 9'h100
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_D_XFER = 3'd1,
        ST_I_XFER = 3'd2,
        ST_I_GAP  = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    state_t        r_state;
    logic [1:0]    r_beat;
    logic          r_owner_i;      // owner of current transfer == last granted
    logic          r_mem_read;
    logic          r_mem_write;
    logic [8:0]    r_mem_address;
    logic [31:0]   r_mem_writedata;
    logic [127:0]  r_i_readdata;
    logic [31:0]   r_d_readdata;

    logic          w_d_req;
    logic          w_grant_d;

    assign w_d_req   = bus.d_read | bus.d_write;
    // On a tie the requester that did not own the previous transfer wins.
    assign w_grant_d = w_d_req & (~bus.i_read | r_owner_i);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_beat          <= 2'd0;
            r_owner_i       <= 1'b1;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_mem_address   <= 9'd0;
            r_mem_writedata <= 32'd0;
            r_i_readdata    <= 128'd0;
            r_d_readdata    <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_d) begin
                        r_state         <= ST_D_XFER;
                        r_owner_i       <= 1'b0;
                        r_mem_address   <= D_BASE + {3'b000, bus.d_address};
                        r_mem_writedata <= bus.d_writedata;
                        // a simultaneous read+write request is a write
                        r_mem_write     <= bus.d_write;
                        r_mem_read      <= ~bus.d_write;
                    end else if (bus.i_read) begin
                        r_state       <= ST_I_XFER;
                        r_owner_i     <= 1'b1;
                        r_beat        <= 2'd0;
                        r_mem_read    <= 1'b1;
                        r_mem_write   <= 1'b0;
                        r_mem_address <= {1'b0, bus.i_address, 2'b00};
                    end
                end

                ST_D_XFER: begin
                    if (!bus.mem_busywait) begin
                        if (!r_mem_write) begin
                            r_d_readdata <= bus.mem_readdata;
                        end
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_state     <= ST_RESP;
                    end
                end

                ST_I_XFER: begin
                    if (!bus.mem_busywait) begin
                        r_i_readdata[{r_beat, 5'b00000} +: 32] <= bus.mem_readdata;
                        r_mem_read <= 1'b0;
                        r_state    <= (r_beat == 2'd3) ? ST_RESP : ST_I_GAP;
                    end
                end

                ST_I_GAP: begin
                    // block address stays latched from the grant; only the word index moves
                    r_beat        <= r_beat + 2'd1;
                    r_mem_address <= {r_mem_address[8:2], r_beat + 2'd1};
                    r_mem_read    <= 1'b1;
                    r_state       <= ST_I_XFER;
                end

                ST_RESP: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                end
            endcase
        end
    end

    assign bus.i_busywait    = bus.i_read & ~((r_state == ST_RESP) &  r_owner_i);
    assign bus.d_busywait    = w_d_req    & ~((r_state == ST_RESP) & ~r_owner_i);
    assign bus.mem_read      = r_mem_read;
    assign bus.mem_write     = r_mem_write;
    assign bus.mem_address   = r_mem_address;
    assign bus.mem_writedata = r_mem_writedata;
    assign bus.i_readdata    = r_i_readdata;
    assign bus.d_readdata    = r_d_readdata;

endmodule
`default_nettype wire
